// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: types and constants shared by the uart
// transmit/receive control blocks.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ARB,
    LAUNCH,
    BUSY
  } tx_state_t;

  localparam int TMO_W   = 16;
  localparam int MAX_REQ = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set
// bit of req at or above ptr with wrap-around.
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the uart transmit
// path with optional frame lock and launch timeout.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int LAUNCH_TIMEOUT = 255,
  localparam int IW             = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_is_transmitting,
  output logic [IW-1:0]        grant_id,
  output logic                 locked,
  output logic                 launch_error
);

  localparam logic [TMO_W-1:0] TMO =
    TMO_W'(LAUNCH_TIMEOUT);
  localparam logic [IW-1:0] LAST_ID =
    IW'(NUM_REQ - 1);

  tx_state_t          state;
  tx_state_t          state_nx;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      acc_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic               accept;
  logic               tmo_hit;
  logic [TMO_W-1:0]   cnt;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    req_ready = '0;
    if (!rst && state == ARB) begin
      if (locked)
        req_ready[grant_id] = req_valid[grant_id];
      else
        req_ready = pick_gnt;
    end
  end

  assign acc_idx = locked ? grant_id : pick_idx;
  assign accept  = !rst && state == ARB &&
    (locked ? req_valid[grant_id] : pick_any);

  // a rising is_transmitting beats a same-cycle timeout
  assign tmo_hit = state == LAUNCH &&
    !uart_is_transmitting && cnt == TMO;

  assign uart_transmit = (state == LAUNCH);
  assign launch_error  = !rst && tmo_hit;

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB:
        if (accept) state_nx = LAUNCH;
      LAUNCH:
        if (uart_is_transmitting) state_nx = BUSY;
        else if (tmo_hit) state_nx = ARB;
      BUSY:
        if (!uart_is_transmitting) state_nx = ARB;
      default:
        state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      locked       <= 1'b0;
      uart_tx_byte <= '0;
      cnt          <= '0;
    end else if (accept) begin
      uart_tx_byte <= req_data[{acc_idx, 3'b000} +: 8];
      grant_id     <= acc_idx;
      rr_ptr       <= (acc_idx == LAST_ID) ? '0
                      : acc_idx + 1'b1;
      locked       <= ~req_last[acc_idx];
      cnt          <= TMO_W'(1);
    end else if (state == LAUNCH) begin
      cnt <= cnt + 1'b1;
      if (tmo_hit) locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the
// transmit arbiter against a behavioural uart and rr model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_is_transmitting;
  logic [1:0]  grant_id;
  logic        locked;
  logic        launch_error;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] gate = '1;
  logic [8:0] src_q[4][$];
  logic [8:0] ref_q[4][$];

  int         acc_id[$];
  logic [7:0] acc_byte[$];
  logic       acc_last[$];
  logic [3:0] acc_vld[$];
  logic [3:0] acc_rdy[$];
  logic       acc_locked[$];

  logic       u_busy = 1'b0;
  int         u_cnt = 0;
  bit         u_dead = 1'b0;
  logic [7:0] uart_got[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .LAUNCH_TIMEOUT(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .uart_transmit(uart_transmit),
    .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .grant_id(grant_id),
    .locked(locked),
    .launch_error(launch_error)
  );

  // uart core: latches transmit, busy for 10 cycles
  always @(posedge clk) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_cnt  <= 0;
    end else if (!u_busy) begin
      if (uart_transmit && !u_dead) begin
        u_busy <= 1'b1;
        u_cnt  <= 10;
        uart_got.push_back(uart_tx_byte);
      end
    end else begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) u_busy <= 1'b0;
    end
  end

  assign uart_is_transmitting = u_busy;

  task automatic step(output bit acc);
    logic [3:0] v;
    logic [3:0] r;
    logic [8:0] e;
    int id;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      v[i] = gate[i] && (src_q[i].size() > 0);
      if (v[i]) e = src_q[i][0];
      else e = 9'($urandom);
      req_data[8*i +: 8] = e[7:0];
      req_last[i] = e[8];
    end
    req_valid = v;
    #1 r = req_ready;
    @(posedge clk);
    id = -1;
    for (int i = 3; i >= 0; i--)
      if (v[i] && r[i]) id = i;
    acc = (id >= 0);
    if (acc) begin
      e = src_q[id].pop_front();
      acc_id.push_back(id);
      acc_byte.push_back(e[7:0]);
      acc_last.push_back(e[8]);
      acc_vld.push_back(v);
      acc_rdy.push_back(r);
    end
    #1;
    if (acc) acc_locked.push_back(locked);
  endtask

  task automatic step_until_acc(input int max,
                                output bit ok);
    bit a;
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      step(a);
      if (a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_quiet(input int max, output int txc,
                           output bit ok);
    bit a;
    int q;
    q = 0;
    txc = 0;
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      step(a);
      txc += int'(uart_transmit);
      if (!uart_transmit && !uart_is_transmitting) q++;
      else q = 0;
      if (q >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    gate = '1;
    u_dead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      ref_q[i].delete();
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    acc_id.delete();
    acc_byte.delete();
    acc_last.delete();
    acc_vld.delete();
    acc_rdy.delete();
    acc_locked.delete();
    uart_got.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    n_chk++;
    if (req_ready !== 4'h0)
      $display("FAIL rst_ready: got %b exp 0000", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if ({uart_transmit, locked, launch_error} !== 3'b000)
      $display("FAIL rst_flags: got %b exp 000",
               {uart_transmit, locked, launch_error});
    else n_pass++;
    n_chk++;
    if (grant_id !== 2'd0 || uart_tx_byte !== 8'h00)
      $display("FAIL rst_regs: got gid=%0d byte=%h exp 0/00",
               grant_id, uart_tx_byte);
    else n_pass++;
    n_chk++;
    if (req_ready !== 4'h0)
      $display("FAIL rst_ready2: got %b exp 0000", req_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    int txc;
    do_reset();
    src_q[0].push_back({1'b1, 8'hA5});
    step_until_acc(20, ok);
    n_chk++;
    if (!ok || acc_id[0] !== 0)
      $display("FAIL single_acc: got ok=%0d exp req0", ok);
    else n_pass++;
    n_chk++;
    if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'hA5)
      $display("FAIL single_launch: got tx=%b byte=%h exp 1/a5",
               uart_transmit, uart_tx_byte);
    else n_pass++;
    run_quiet(60, txc, ok);
    txc += 1;
    n_chk++;
    if (!ok || txc !== 2)
      $display("FAIL single_txlen: got %0d ok=%0d exp 2",
               txc, ok);
    else n_pass++;
    n_chk++;
    if (locked !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL single_end: got lk=%b gid=%0d exp 0/0",
               locked, grant_id);
    else n_pass++;
    n_chk++;
    if (uart_got.size() != 1 || uart_got[0] !== 8'hA5)
      $display("FAIL single_uart: got n=%0d exp one a5",
               uart_got.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit a;
    int n;
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++)
        src_q[i].push_back({1'b1, 4'(i), 4'(k)});
    n = 0;
    while (acc_id.size() < 6 && n < 200) begin
      step(a);
      n++;
    end
    n_chk++;
    if (acc_id.size() < 6)
      $display("FAIL rr_count: got %0d exp 6", acc_id.size());
    else n_pass++;
    for (int k = 0; k < 6 && k < acc_id.size(); k++) begin
      n_chk++;
      if (acc_id[k] !== k % 4)
        $display("FAIL rr_order[%0d]: got %0d exp %0d",
                 k, acc_id[k], k % 4);
      else n_pass++;
    end
  endtask

  task automatic test_frame_lock();
    bit ok;
    bit a;
    int n;
    int txc;
    int exp_id[5];
    logic [7:0] exp_b[5];
    exp_id = '{2, 2, 2, 0, 1};
    exp_b  = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
    do_reset();
    gate = 4'b0100;
    src_q[2].push_back({1'b0, 8'h10});
    src_q[2].push_back({1'b0, 8'h11});
    src_q[2].push_back({1'b1, 8'h12});
    step_until_acc(20, ok);
    src_q[0].push_back({1'b1, 8'h20});
    src_q[1].push_back({1'b1, 8'h21});
    gate = 4'b1111;
    n = 0;
    while (acc_id.size() < 5 && n < 300) begin
      step(a);
      n++;
    end
    run_quiet(60, txc, ok);
    n_chk++;
    if (acc_id.size() != 5 || uart_got.size() != 5)
      $display("FAIL lock_count: got %0d/%0d exp 5",
               acc_id.size(), uart_got.size());
    else n_pass++;
    for (int k = 0; k < 5 && k < acc_id.size(); k++) begin
      n_chk++;
      if (acc_id[k] !== exp_id[k] || acc_byte[k] !== exp_b[k])
        $display("FAIL lock_seq[%0d]: got %0d/%h exp %0d/%h",
                 k, acc_id[k], acc_byte[k], exp_id[k], exp_b[k]);
      else n_pass++;
    end
    for (int k = 0; k < 3 && k < acc_locked.size(); k++) begin
      n_chk++;
      if (acc_locked[k] !== (k < 2))
        $display("FAIL lock_flag[%0d]: got %b exp %b",
                 k, acc_locked[k], k < 2);
      else n_pass++;
    end
    for (int k = 0; k < 5 && k < uart_got.size(); k++) begin
      n_chk++;
      if (uart_got[k] !== exp_b[k])
        $display("FAIL lock_uart[%0d]: got %h exp %h",
                 k, uart_got[k], exp_b[k]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit a;
    int txc;
    int errc;
    int err_at;
    logic lk_after;
    do_reset();
    u_dead = 1'b1;
    src_q[1].push_back({1'b0, 8'h55});
    src_q[1].push_back({1'b1, 8'h66});
    src_q[2].push_back({1'b1, 8'h77});
    step_until_acc(20, ok);
    n_chk++;
    if (!ok || acc_id[0] !== 1 || acc_locked[0] !== 1'b1)
      $display("FAIL tmo_first: got ok=%0d exp req1 locked", ok);
    else n_pass++;
    txc = int'(uart_transmit);
    errc = int'(launch_error);
    err_at = -1;
    lk_after = 1'bx;
    a = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step(a);
      if (a) break;
      txc += int'(uart_transmit);
      errc += int'(launch_error);
      if (launch_error) err_at = txc;
      if (!uart_transmit) lk_after = locked;
    end
    n_chk++;
    if (txc !== 5)
      $display("FAIL tmo_txlen: got %0d exp 5", txc);
    else n_pass++;
    n_chk++;
    if (errc !== 1 || err_at !== 5)
      $display("FAIL tmo_err: got n=%0d at=%0d exp 1 at 5",
               errc, err_at);
    else n_pass++;
    n_chk++;
    if (lk_after !== 1'b0)
      $display("FAIL tmo_unlock: got %b exp 0", lk_after);
    else n_pass++;
    n_chk++;
    if (!a || acc_id.size() < 2 || acc_id[1] !== 2)
      $display("FAIL tmo_next: got acc=%0d exp req2", a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    do_reset();
    src_q[0].push_back({1'b0, 8'hE1});
    src_q[0].push_back({1'b1, 8'hE2});
    step_until_acc(20, ok);
    n_chk++;
    if (!ok || acc_locked[0] !== 1'b1)
      $display("FAIL rmid_lock: got ok=%0d exp locked", ok);
    else n_pass++;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = uart_is_transmitting && !uart_transmit;
    end
    n_chk++;
    if (!seen)
      $display("FAIL rmid_busy: got no BUSY exp BUSY");
    else n_pass++;
    rst = 1'b1;
    req_valid = 4'b0011;
    #1;
    n_chk++;
    if (req_ready !== 4'h0)
      $display("FAIL rmid_ready: got %b exp 0000", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (uart_transmit !== 1'b0 || locked !== 1'b0 ||
        grant_id !== 2'd0 || uart_tx_byte !== 8'h00)
      $display("FAIL rmid_regs: got tx=%b lk=%b gid=%0d b=%h exp 0",
               uart_transmit, locked, grant_id, uart_tx_byte);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    src_q[0].delete();
    src_q[0].push_back({1'b1, 8'hC0});
    src_q[1].push_back({1'b1, 8'hC1});
    acc_id.delete();
    step_until_acc(20, ok);
    n_chk++;
    if (!ok || acc_id[0] !== 0)
      $display("FAIL rmid_first: got ok=%0d exp req0", ok);
    else n_pass++;
  endtask

  task automatic test_stability();
    bit ok;
    bit a;
    int q;
    do_reset();
    src_q[0].push_back({1'b1, 8'h3C});
    step_until_acc(20, ok);
    q = 0;
    for (int n = 0; n < 40 && q < 3; n++) begin
      step(a);
      n_chk++;
      if (uart_tx_byte !== 8'h3C)
        $display("FAIL stab_byte[%0d]: got %h exp 3c",
                 n, uart_tx_byte);
      else n_pass++;
      if (!uart_transmit && !uart_is_transmitting) q++;
      else q = 0;
    end
    src_q[1].push_back({1'b1, 8'h99});
    step_until_acc(20, ok);
    n_chk++;
    if (!ok || uart_tx_byte !== 8'h99)
      $display("FAIL stab_next: got %h exp 99", uart_tx_byte);
    else n_pass++;
  endtask

  task automatic test_random();
    bit a;
    bit ok;
    int n;
    int txc;
    int total;
    int mptr;
    int mg;
    int ex;
    int c;
    bit mlk;
    logic [8:0] e;
    do_reset();
    total = 0;
    for (int i = 0; i < 4; i++)
      for (int f = 0; f < 3; f++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          e = {1'(b == len - 1), 8'($urandom)};
          src_q[i].push_back(e);
          ref_q[i].push_back(e);
          total++;
        end
      end
    n = 0;
    while ((src_q[0].size() + src_q[1].size() +
            src_q[2].size() + src_q[3].size()) > 0 &&
           n < 4000) begin
      for (int i = 0; i < 4; i++)
        gate[i] = ($urandom_range(0, 3) != 0);
      step(a);
      n++;
    end
    gate = '1;
    run_quiet(60, txc, ok);
    n_chk++;
    if (acc_id.size() != total || !ok)
      $display("FAIL rnd_count: got %0d exp %0d",
               acc_id.size(), total);
    else n_pass++;
    mptr = 0;
    mg = 0;
    mlk = 1'b0;
    for (int k = 0; k < acc_id.size(); k++) begin
      ex = -1;
      if (mlk) ex = mg;
      else
        for (int j = 0; j < 4; j++) begin
          c = (mptr + j) % 4;
          if (ex < 0 && acc_vld[k][c]) ex = c;
        end
      n_chk++;
      if (acc_id[k] !== ex)
        $display("FAIL rnd_pick[%0d]: got %0d exp %0d",
                 k, acc_id[k], ex);
      else n_pass++;
      n_chk++;
      if ($countones(acc_rdy[k]) != 1)
        $display("FAIL rnd_onehot[%0d]: got %b exp one-hot",
                 k, acc_rdy[k]);
      else n_pass++;
      e = ref_q[acc_id[k]].size() > 0 ?
          ref_q[acc_id[k]].pop_front() : 9'h000;
      n_chk++;
      if (acc_locked[k] !== !e[8])
        $display("FAIL rnd_lock[%0d]: got %b exp %b",
                 k, acc_locked[k], !e[8]);
      else n_pass++;
      n_chk++;
      if (k >= uart_got.size() || uart_got[k] !== e[7:0])
        $display("FAIL rnd_uart[%0d]: got n=%0d exp %h",
                 k, uart_got.size(), e[7:0]);
      else n_pass++;
      mg = acc_id[k];
      mptr = (mg + 1) % 4;
      mlk = !e[8];
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_frame_lock();
    test_timeout();
    test_reset_mid();
    test_stability();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
